opb_register_simulink2ppc: RTL and testbench

OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

---
 rtl/opb_s2p_pkg.sv | 43 ++++
 rtl/opb_register_simulink2ppc_if.sv | 32 +++
 rtl/opb_slave_ack_fsm.sv | 76 +++++++
 rtl/opb_register_simulink2ppc.sv | 151 +++++++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_s2p_pkg.sv
// ---------------------------------------------------------------------------
// opb_s2p_pkg
// Shared definitions for the Simulink-to-PPC OPB capture register block:
//   - register word offsets (OPB_ABus[28:29])
//   - bus acknowledge state machine encoding
//   - STATUS / CTRL field positions and widths
//   - pack_status(): assembles the STATUS read word
// ---------------------------------------------------------------------------
package opb_s2p_pkg;

    // Word offsets within the slave window
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_TSTAMP = 2'd3;

    // Bus acknowledge state machine
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAck  = 2'd1,
        StWait = 2'd2
    } ack_state_e;

    // STATUS layout (little-endian register bit numbering)
    localparam int unsigned STATUS_VALID_BIT = 0;
    localparam int unsigned STATUS_OVF_LSB   = 8;
    localparam int unsigned STATUS_OVF_W     = 8;

    // CTRL layout: writing 1 here clears valid and overflow
    localparam int unsigned CTRL_CLR_BIT = 0;

    localparam logic [STATUS_OVF_W-1:0] OVF_MAX = '1;

    function automatic logic [31:0] pack_status(input logic                    valid,
                                                input logic [STATUS_OVF_W-1:0] ovf);
        logic [31:0] s;
        s                                   = '0;
        s[STATUS_VALID_BIT]                 = valid;
        s[STATUS_OVF_LSB +: STATUS_OVF_W]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc_if
// OPB slave-side bus bundle. Vectors keep the OPB big-endian [0:N] numbering.
//   master modport : drives OPB_* request signals, samples Sl_* responses
//   slave  modport : samples OPB_* request signals, drives Sl_* responses
// ---------------------------------------------------------------------------
interface opb_register_simulink2ppc_if;

    logic [0:31] OPB_ABus;
    logic [0:31] OPB_DBus;
    logic [0:3]  OPB_BE;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;

    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_DBus, OPB_BE, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_DBus, OPB_BE, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_slave_ack_fsm.sv
// ---------------------------------------------------------------------------
// opb_slave_ack_fsm
// Address decode and single-beat acknowledge generation for the OPB slave.
// A hit sampled in idle produces a one-cycle registered ack; the machine then
// waits for OPB_select to drop before accepting another transfer.
//   OPB_Clk, OPB_Rst_n : clock, asynchronous active-low reset
//   i_abus, i_select, i_rnw : OPB request (address big-endian [0:31])
//   o_ack      : registered transfer acknowledge (one cycle)
//   o_rnw      : direction latched with the hit
//   o_offset   : word offset latched with the hit
// ---------------------------------------------------------------------------
module opb_slave_ack_fsm
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_0300,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_03FF
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [0:31] i_abus,
    input  logic        i_select,
    input  logic        i_rnw,
    output logic        o_ack,
    output logic        o_rnw,
    output logic [1:0]  o_offset
);

    ack_state_e  r_state;
    logic        r_ack;
    logic        r_rnw;
    logic [1:0]  r_offset;
    logic [31:0] w_addr;
    logic        w_hit;

    // Plain numeric view of the big-endian address
    assign w_addr = i_abus;
    assign w_hit  = i_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state  <= StIdle;
            r_ack    <= 1'b0;
            r_rnw    <= 1'b0;
            r_offset <= OFF_DATA;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_hit) begin
                        r_state  <= StAck;
                        r_ack    <= 1'b1;
                        r_rnw    <= i_rnw;
                        r_offset <= i_abus[28:29];
                    end
                end
                StAck: begin
                    r_state <= StWait;
                end
                StWait: begin
                    // Master must release select before the next transfer
                    if (!i_select) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_ack    = r_ack;
    assign o_rnw    = r_rnw;
    assign o_offset = r_offset;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc
// OPB slave that captures a 32-bit fabric value for the PowerPC.
//   OPB_Clk, OPB_Rst_n : clock, asynchronous active-low reset
//   opb_bus            : OPB slave bundle (opb_register_simulink2ppc_if.slave)
//   user_data_in       : value loaded into DATA on a capture
//   user_valid         : capture strobe
//   user_new_pending   : mirror of the STATUS valid flag
// Registers (word offsets): 0x0 DATA (RO), 0x4 STATUS (RO: valid, overflow
// count in [15:8]), 0x8 CTRL (WO, bit0 clears), 0xC TSTAMP.
// Build option: define SIMULINK2PPC_TIMESTAMP_EN to add a free-running cycle
// counter sampled into TSTAMP on every capture; otherwise 0xC reads zero.
// ---------------------------------------------------------------------------
module opb_register_simulink2ppc
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0300,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_03FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    opb_register_simulink2ppc_if.slave  opb_bus,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_valid,
    output logic                        user_new_pending
);

    // Informational parameters; the bus is fixed at 32 bits
    localparam int          unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;
    localparam logic [55:0] unused_family = C_FAMILY;

    logic                    w_ack;
    logic                    w_ack_rnw;
    logic [1:0]              w_ack_off;
    logic [31:0]             w_wdata;
    logic                    w_rd_clr;
    logic                    w_ctrl_clr;
    logic                    w_ovf_inc;
    logic [31:0]             w_rdata;
    logic [31:0]             w_tstamp;
    logic                    w_unused_bus;

    logic [31:0]             r_data;
    logic                    r_valid;
    logic [STATUS_OVF_W-1:0] r_ovf;
    logic [31:0]             w_data_d;
    logic                    w_valid_d;
    logic [STATUS_OVF_W-1:0] w_ovf_d;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .OPB_Clk   (OPB_Clk),
        .OPB_Rst_n (OPB_Rst_n),
        .i_abus    (opb_bus.OPB_ABus),
        .i_select  (opb_bus.OPB_select),
        .i_rnw     (opb_bus.OPB_RNW),
        .o_ack     (w_ack),
        .o_rnw     (w_ack_rnw),
        .o_offset  (w_ack_off)
    );

    // Little-endian view of write data; master holds it until ack
    assign w_wdata = opb_bus.OPB_DBus;

    assign w_unused_bus = ^{opb_bus.OPB_BE, opb_bus.OPB_seqAddr, w_wdata[31:1]};

    assign w_rd_clr   = w_ack && w_ack_rnw && (w_ack_off == OFF_DATA);
    assign w_ctrl_clr = w_ack && !w_ack_rnw && (w_ack_off == OFF_CTRL) &&
                        w_wdata[CTRL_CLR_BIT];

    // A capture only counts as overflow if nothing is clearing the flag now
    assign w_ovf_inc = user_valid && r_valid && !w_rd_clr && !w_ctrl_clr &&
                       (r_ovf != OVF_MAX);

    always_comb begin
        w_data_d  = r_data;
        w_valid_d = r_valid;
        w_ovf_d   = r_ovf;
        if (user_valid) begin
            w_data_d  = user_data_in;
            w_valid_d = 1'b1;
        end else if (w_rd_clr || w_ctrl_clr) begin
            w_valid_d = 1'b0;
        end
        if (w_ctrl_clr) begin
            w_ovf_d = '0;
        end else if (w_ovf_inc) begin
            w_ovf_d = r_ovf + 1'b1;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= '0;
        end else begin
            r_data  <= w_data_d;
            r_valid <= w_valid_d;
            r_ovf   <= w_ovf_d;
        end
    end

`ifdef SIMULINK2PPC_TIMESTAMP_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_tstamp;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_cycle_cnt <= '0;
            r_tstamp    <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (user_valid) begin
                r_tstamp <= r_cycle_cnt;
            end
        end
    end

    assign w_tstamp = r_tstamp;
`else
    assign w_tstamp = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_ack_off)
            OFF_DATA:   w_rdata = r_data;
            OFF_STATUS: w_rdata = pack_status(r_valid, r_ovf);
            OFF_CTRL:   w_rdata = '0;
            OFF_TSTAMP: w_rdata = w_tstamp;
            default:    w_rdata = '0;
        endcase
    end

    // Register values are used pre-edge, so a same-edge capture is not visible
    // on the bus; zero outside read acks keeps the OR-bus clean.
    assign opb_bus.Sl_DBus    = (w_ack && w_ack_rnw) ? w_rdata : '0;
    assign opb_bus.Sl_xferAck = w_ack;
    assign opb_bus.Sl_errAck  = 1'b0;
    assign opb_bus.Sl_retry   = 1'b0;
    assign opb_bus.Sl_toutSup = 1'b0;

    assign user_new_pending = r_valid;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE = 32'h0100_0300;
    localparam logic [31:0] HIGH = 32'h0100_03FF;

    logic        clk;
    logic        rst_n;
    logic [31:0] user_data_in;
    logic        user_valid;
    logic        user_new_pending;

    opb_register_simulink2ppc_if bus ();

    opb_register_simulink2ppc #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex5")
    ) dut (
        .OPB_Clk          (clk),
        .OPB_Rst_n        (rst_n),
        .opb_bus          (bus),
        .user_data_in     (user_data_in),
        .user_valid       (user_valid),
        .user_new_pending (user_new_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_acks = 0;

    // Reference model state
    logic [31:0] m_data   = '0;
    logic        m_valid  = 1'b0;
    int          m_ovf    = 0;
    logic [31:0] m_cyc    = '0;
    logic [31:0] m_tstamp = '0;

    logic [31:0] exp_q[$];
    bit          rand_cap = 1'b0;
    bit          cap_req  = 1'b0;
    logic [31:0] cap_val  = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return m_data;
            2'd1:    return {16'h0, m_ovf[7:0], 7'h0, m_valid};
            2'd2:    return 32'h0;
`ifdef SIMULINK2PPC_TIMESTAMP_EN
            default: return m_tstamp;
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    // One clock edge; rd_clr/ctrl_clr say whether this edge completes an
    // acked DATA read or a CTRL clear write.
    task automatic tick(input bit rd_clr, input bit ctrl_clr);
        bit          uv;
        logic [31:0] ud;
        uv      = cap_req || (rand_cap && ($urandom_range(0, 2) == 0));
        ud      = cap_req ? cap_val : $urandom;
        cap_req = 1'b0;
        user_valid   = uv;
        user_data_in = ud;
        @(posedge clk);
        if (ctrl_clr) m_ovf = 0;
        else if (uv && m_valid && !rd_clr && m_ovf < 255) m_ovf = m_ovf + 1;
        if (uv) begin
            m_data   = ud;
            m_valid  = 1'b1;
            m_tstamp = m_cyc;
        end else if (rd_clr || ctrl_clr) begin
            m_valid = 1'b0;
        end
        m_cyc = m_cyc + 32'd1;
        #1;
        user_valid = 1'b0;
    endtask

    // Full OPB transfer: request, ack cycle, optional extra select hold, release
    task automatic bus_xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wdata,
                            input int hold, input bit cap_ack, input logic [31:0] cap_v);
        bit         hit;
        logic [1:0] off;
        int         a0;
        hit = (addr >= BASE) && (addr <= HIGH);
        off = addr[3:2];
        a0  = n_acks;
        bus.OPB_select  = 1'b1;
        bus.OPB_ABus    = addr;
        bus.OPB_RNW     = rnw;
        bus.OPB_DBus    = rnw ? 32'h0 : wdata;
        bus.OPB_BE      = 4'($urandom);
        bus.OPB_seqAddr = 1'($urandom);
        tick(1'b0, 1'b0);
        if (hit) exp_q.push_back(rnw ? model_read(off) : 32'h0);
        if (cap_ack) begin
            cap_req = 1'b1;
            cap_val = cap_v;
        end
        tick(hit && rnw && off == 2'd0, hit && !rnw && off == 2'd2 && wdata[0]);
        for (int i = 0; i < hold; i++) tick(1'b0, 1'b0);
        bus.OPB_select = 1'b0;
        bus.OPB_DBus   = '0;
        tick(1'b0, 1'b0);
        check("ack_count", 32'(n_acks - a0), 32'(hit));
    endtask

    task automatic rd(input logic [31:0] addr);
        bus_xfer(addr, 1'b1, 32'h0, 0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        bus_xfer(addr, 1'b0, d, 0, 1'b0, 32'h0);
    endtask

    task automatic capture(input logic [31:0] d);
        cap_req = 1'b1;
        cap_val = d;
        tick(1'b0, 1'b0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n) begin
            check("pending", {31'h0, user_new_pending}, {31'h0, m_valid});
            check("tie_offs", {29'h0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
            if (bus.Sl_xferAck === 1'b1) begin
                n_acks++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got ack with data %h, expected no ack at %0t",
                             bus.Sl_DBus, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", bus.Sl_DBus, e);
                end
            end else begin
                check("idle_dbus", bus.Sl_DBus, 32'h0);
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        user_valid      = 1'b0;
        user_data_in    = '0;
        bus.OPB_select  = 1'b1;
        bus.OPB_ABus    = BASE + 32'h4;
        bus.OPB_RNW     = 1'b1;
        bus.OPB_DBus    = '0;
        bus.OPB_BE      = 4'hF;
        bus.OPB_seqAddr = 1'b0;

        // Reset held with select asserted
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_ack", {31'h0, bus.Sl_xferAck}, 32'h0);
            check("rst_dbus", bus.Sl_DBus, 32'h0);
            check("rst_pending", {31'h0, user_new_pending}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd(BASE + 32'h4);                   // select still high: new hit, STATUS = 0

        // Capture and read
        capture(32'hDEAD_BEEF);
        rd(BASE + 32'h0);
        rd(BASE + 32'h4);

        // Overflow saturation then CTRL clear
        for (int i = 0; i < 300; i++) capture($urandom);
        rd(BASE + 32'h4);
        wr(BASE + 32'h8, 32'h0000_0001);
        rd(BASE + 32'h4);

        // Capture colliding with a completing DATA read
        capture(32'h11);
        bus_xfer(BASE + 32'h0, 1'b1, 32'h0, 0, 1'b1, 32'h22);
        rd(BASE + 32'h4);
        rd(BASE + 32'h0);

        // Window edges and WAIT hold
        rd(HIGH + 32'h4);
        rd(BASE - 32'h4);
        rd(HIGH - 32'h3);
        bus_xfer(BASE + 32'h4, 1'b1, 32'h0, 3, 1'b0, 32'h0);

        // Timestamp: captures 10 cycles apart
        capture(32'hA5A5_0001);
        rd(BASE + 32'hC);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        capture(32'hA5A5_0002);
        rd(BASE + 32'hC);

        // Capture with a simultaneous CTRL clear: valid stays, overflow zero
        capture(32'h1);
        bus_xfer(BASE + 32'h8, 1'b0, 32'h1, 0, 1'b1, 32'h2);
        rd(BASE + 32'h4);

        // Randomized mix
        rand_cap = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: tick(1'b0, 1'b0);
                1, 2: bus_xfer(BASE + $urandom_range(0, 255), 1'b1, 32'h0,
                               $urandom_range(0, 2), 1'b0, 32'h0);
                3: bus_xfer(BASE + 32'h8 + 32'($urandom_range(0, 15)) * 16, 1'b0, $urandom,
                            $urandom_range(0, 2), 1'b0, 32'h0);
                4: bus_xfer(BASE + {$urandom_range(0, 63), 2'b00}, 1'b0, $urandom,
                            0, 1'b0, 32'h0);
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        rd(HIGH + 32'd1 + $urandom_range(0, 1023));
                    else
                        rd(BASE - 32'd1 - $urandom_range(0, 1023));
                end
            endcase
        end
        rand_cap = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("leftover_expect", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
